toeplitz_src_buf: RTL and testbench
===================================

# toeplitz_src_buf

Single-bank source buffer that sits directly upstream of `toeplitz_mat`. It accepts a stream of 16-bit matrix coefficients over a valid/ready write port and stores them sequentially. Once the bank is full it pulses `start` to the Toeplitz engine, then serves that engine's `addr`/`rd` reads with registered `data`. It reopens for loading when the engine signals `done`.

## Interface
- `DW`, 16: data word width.
- `AW`, 8: read address width; matches `toeplitz_mat.addr`.
- `DEPTH`, 256: words per matrix load; legal range 2 to 2^AW.

Ports:
- `clk`  in  1  single clock; everything is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wr_valid`  in  1  write word present.
- `wr_data`  in  DW  write word.
- `wr_ready`  out  1  buffer accepts a word this cycle.
- `start`  out  1  one-cycle pulse: bank full, engine may read; drives `toeplitz_mat.start`.
- `addr`  in  AW  read address from the engine.
- `rd`  in  1  read strobe from the engine.
- `data`  out  DW  read data; drives `toeplitz_mat.data`.
- `done`  in  1  engine finished with the bank; single-cycle pulse.
- `fill`  out  AW+1  number of words written in the current load.
- `busy`  out  1  high in START and SERVE.

## Operation
- Storage is DEPTH x DW; synchronous write, registered read.
- States: LOAD, START, SERVE. `rst` forces LOAD.
- LOAD:
  - `wr_ready` = 1 whenever `rst` is low.
  - On `wr_valid && wr_ready`, write `mem[wr_ptr]` and increment `wr_ptr` and `fill`.
  - When the word at `wr_ptr == DEPTH-1` is accepted, go to START.
- START: lasts exactly one cycle with `start` = 1, then go to SERVE. `wr_ready` = 0.
- SERVE:
  - `wr_ready` = 0.
  - On `rd`, `data` <= `mem[addr]`. If `addr >= DEPTH`, `data` <= 0.
  - Without `rd`, `data` holds its last value.
  - On `done`, go to LOAD and clear `wr_ptr` and `fill` to 0. Memory contents are not cleared.
- `rd` outside SERVE is ignored: `data` holds.
- `done` outside SERVE is ignored.
- `rd` and `done` in the same SERVE cycle: the read is performed and the state changes. `data` shows the read value in the first LOAD cycle.
- `wr_valid` while `wr_ready` = 0: the word is not taken, and the source must hold it.
- `fill` saturates at DEPTH. It reads DEPTH in START and SERVE.

## Timing
- Reset values:
  - state = LOAD, `wr_ptr` = 0, `fill` = 0, `data` = 0, `start` = 0, `busy` = 0.
  - `wr_ready` = 0 while `rst` is high, and 1 in the first cycle after `rst` falls.
- Write throughput: one word per cycle. A gapless burst of DEPTH words completes in DEPTH cycles.
- `start` rises in the cycle after the edge that accepts the last word. It stays high exactly one cycle.
- `busy` rises with `start` and falls in the cycle after the `done` edge.
- Read latency is 1: with `rd` sampled at edge N, `data` is valid after edge N and holds until the next sampled `rd`.
- Earliest reload: `wr_ready` = 1 in the cycle after the edge that samples `done`.
- `rst` mid-operation (any state) takes effect at the next edge:
  - `start` is not emitted.
  - Partially loaded data is abandoned; the next load restarts at address 0.
- Depth wrap: `wr_ptr` never wraps inside one load; a reload resets it to 0.

## Test plan
- Reset check: hold `rst` 2 cycles → `wr_ready` = 0, `start` = 0, `data` = 0, `fill` = 0; the cycle after release `wr_ready` = 1.
- Fill and start: gapless burst of 256 words with value `16'hAA00 + i` → `fill` reaches 256, `start` is a single pulse the cycle after the 256th accept, `wr_ready` = 0 afterwards.
- Serve reads:
  - `rd` with `addr` = 0, 5, 255 → `data` = `16'hAA00`, `16'hAA05`, `16'hAAFF` one cycle later.
  - `rd` low → `data` holds.
  - Extra `wr_valid` pulses → not accepted, `fill` stays 256.
- Backpressure and gaps: `wr_valid` toggled randomly during LOAD → exactly 256 writes, in order; readback matches.
- Reload: `done` pulse in the same cycle as `rd` with `addr` = 3 → `data` = `16'hAA03`, `wr_ready` = 1 next cycle, `fill` = 0. Load `16'h1122` x 256 → second `start` pulse, reads return `16'h1122`.
- Mid-load reset: reset after 100 words → no `start`, `fill` = 0. Reload the full depth → reads at addr 0 return the new data.

Source files
------------

// File: rtl/toeplitz_src_buf.sv
// toeplitz_src_buf: single-bank coefficient buffer that loads a matrix, starts toeplitz_mat, then serves its reads
//   clk, rst        : clock, synchronous active-high reset
//   wr_valid/wr_data/wr_ready : valid/ready write stream of DW-bit coefficients
//   start           : one-cycle pulse when the bank is full
//   addr/rd/data    : engine read port, one-cycle registered read latency
//   done            : engine finished, bank reopens for loading
//   fill            : words written in the current load
//   busy            : bank owned by the engine (START or SERVE)
module toeplitz_src_buf #(
  parameter int DW    = 16,
  parameter int AW    = 8,
  parameter int DEPTH = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_valid,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ready,
  output logic          start,
  input  logic [AW-1:0] addr,
  input  logic          rd,
  output logic [DW-1:0] data,
  input  logic          done,
  output logic [AW:0]   fill,
  output logic          busy
);
  typedef enum logic [1:0] {LOAD, START, SERVE} state_t;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_L = AW'(DEPTH-1);
  state_t state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] fill_q, fill_d;
  logic [DW-1:0] data_q, data_d;
  logic [DW-1:0] mem [DEPTH];
  logic acc, last, rel;
  assign acc  = wr_valid && wr_ready;
  assign last = acc && wr_ptr_q == LAST_L;
  assign rel  = state_q == SERVE && done;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= LOAD;
      wr_ptr_q <= '0;
      fill_q   <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
      data_q   <= data_d;
    end
  end
  always_ff @(posedge clk) begin
    if (acc) mem[wr_ptr_q] <= wr_data;
  end
  always_comb begin
    state_d  = state_q == LOAD  ? (last ? START : LOAD) :
               state_q == START ? SERVE :
               (done ? LOAD : SERVE);
    wr_ptr_d = rel ? '0 : acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
    // acc is only possible in LOAD before the last word, so fill stops at DEPTH
    fill_d   = rel ? '0 : (acc && fill_q != DEPTH_L) ? fill_q + 1'b1 : fill_q;
    data_d   = (state_q == SERVE && rd) ? ({1'b0, addr} < DEPTH_L ? mem[addr] : '0) : data_q;
  end
  always_comb begin
    wr_ready = state_q == LOAD && !rst;
    start    = state_q == START;
    busy     = state_q != LOAD;
    data     = data_q;
    fill     = fill_q;
  end
endmodule

// File: tb/tb_toeplitz_src_buf.sv
// tb_toeplitz_src_buf: directed self-checking bench for toeplitz_src_buf
module tb_toeplitz_src_buf;
  logic clk = 0, rst = 1, wr_valid = 0, rd = 0, done = 0;
  logic [15:0] wr_data = 0;
  logic [7:0] addr = 0;
  logic wr_ready, start, busy;
  logic [15:0] data;
  logic [8:0] fill;
  int errors = 0, checks = 0;

  toeplitz_src_buf dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .start(start), .addr(addr), .rd(rd), .data(data), .done(done), .fill(fill), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_burst(input logic [15:0] base, input logic [15:0] step, input int n, output int early);
    early = 0;
    wr_valid = 1;
    for (int i = 0; i < n; i++) begin
      wr_data = base + step * 16'(i);
      tick();
      if (i < n - 1 && start) early++;
    end
    wr_valid = 0;
  endtask

  task automatic do_read(input logic [7:0] a);
    rd = 1;
    addr = a;
    tick();
    rd = 0;
  endtask

  task automatic test_reset;
    rst = 1;
    tick();
    tick();
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL rst_wr_ready got=%b exp=0", wr_ready); end
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL rst_start got=%b exp=0", start); end
    checks++; if (data !== 16'h0) begin errors++; $display("FAIL rst_data got=%h exp=0000", data); end
    checks++; if (fill !== 9'd0) begin errors++; $display("FAIL rst_fill got=%0d exp=0", fill); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
    rst = 0;
    #1;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rel_wr_ready got=%b exp=1", wr_ready); end
  endtask

  task automatic test_fill;
    int early;
    load_burst(16'hAA00, 16'd1, 256, early);
    checks++; if (early !== 0) begin errors++; $display("FAIL fill_early_start got=%0d exp=0", early); end
    checks++; if (start !== 1'b1) begin errors++; $display("FAIL fill_start got=%b exp=1", start); end
    checks++; if (fill !== 9'd256) begin errors++; $display("FAIL fill_count got=%0d exp=256", fill); end
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL fill_wr_ready got=%b exp=0", wr_ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fill_busy got=%b exp=1", busy); end
    tick();
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL start_width got=%b exp=0", start); end
    checks++; if (fill !== 9'd256) begin errors++; $display("FAIL fill_serve got=%0d exp=256", fill); end
  endtask

  task automatic test_serve;
    do_read(8'd0);
    checks++; if (data !== 16'hAA00) begin errors++; $display("FAIL rd0 got=%h exp=aa00", data); end
    do_read(8'd5);
    checks++; if (data !== 16'hAA05) begin errors++; $display("FAIL rd5 got=%h exp=aa05", data); end
    do_read(8'd255);
    checks++; if (data !== 16'hAAFF) begin errors++; $display("FAIL rd255 got=%h exp=aaff", data); end
    addr = 8'd7;
    tick();
    tick();
    checks++; if (data !== 16'hAAFF) begin errors++; $display("FAIL rd_hold got=%h exp=aaff", data); end
    wr_valid = 1;
    wr_data = 16'hDEAD;
    #1;
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL serve_wr_ready got=%b exp=0", wr_ready); end
    tick();
    tick();
    wr_valid = 0;
    checks++; if (fill !== 9'd256) begin errors++; $display("FAIL serve_fill got=%0d exp=256", fill); end
    do_read(8'd0);
    checks++; if (data !== 16'hAA00) begin errors++; $display("FAIL serve_nowrite got=%h exp=aa00", data); end
  endtask

  task automatic test_reload;
    int early;
    rd = 1;
    addr = 8'd3;
    done = 1;
    tick();
    rd = 0;
    done = 0;
    checks++; if (data !== 16'hAA03) begin errors++; $display("FAIL reload_data got=%h exp=aa03", data); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reload_wr_ready got=%b exp=1", wr_ready); end
    checks++; if (fill !== 9'd0) begin errors++; $display("FAIL reload_fill got=%0d exp=0", fill); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reload_busy got=%b exp=0", busy); end
    load_burst(16'h1122, 16'd0, 256, early);
    checks++; if (early !== 0 || start !== 1'b1) begin errors++; $display("FAIL reload_start got=%0d/%b exp=0/1", early, start); end
    tick();
    do_read(8'd0);
    checks++; if (data !== 16'h1122) begin errors++; $display("FAIL reload_rd0 got=%h exp=1122", data); end
    do_read(8'd200);
    checks++; if (data !== 16'h1122) begin errors++; $display("FAIL reload_rd200 got=%h exp=1122", data); end
  endtask

  task automatic test_gaps;
    int accepted = 0, cyc = 0, early = 0;
    logic a;
    done = 1;
    tick();
    done = 0;
    while (accepted < 256 && cyc < 5000) begin
      wr_valid = 1'($urandom_range(0, 1));
      wr_data = 16'h5500 + 16'(accepted);
      #1;
      a = wr_valid && wr_ready;
      tick();
      if (a) accepted++;
      if (accepted < 256 && start) early++;
      cyc++;
    end
    wr_valid = 0;
    checks++; if (accepted !== 256) begin errors++; $display("FAIL gaps_timeout got=%0d exp=256", accepted); end
    checks++; if (early !== 0 || start !== 1'b1) begin errors++; $display("FAIL gaps_start got=%0d/%b exp=0/1", early, start); end
    checks++; if (fill !== 9'd256) begin errors++; $display("FAIL gaps_fill got=%0d exp=256", fill); end
    tick();
    do_read(8'd0);
    checks++; if (data !== 16'h5500) begin errors++; $display("FAIL gaps_rd0 got=%h exp=5500", data); end
    do_read(8'd1);
    checks++; if (data !== 16'h5501) begin errors++; $display("FAIL gaps_rd1 got=%h exp=5501", data); end
    do_read(8'd128);
    checks++; if (data !== 16'h5580) begin errors++; $display("FAIL gaps_rd128 got=%h exp=5580", data); end
    do_read(8'd255);
    checks++; if (data !== 16'h55FF) begin errors++; $display("FAIL gaps_rd255 got=%h exp=55ff", data); end
  endtask

  task automatic test_mid_reset;
    int early;
    done = 1;
    tick();
    done = 0;
    load_burst(16'h7700, 16'd1, 100, early);
    checks++; if (early !== 0 || start !== 1'b0 || fill !== 9'd100) begin errors++; $display("FAIL mid_partial got=%0d/%b/%0d exp=0/0/100", early, start, fill); end
    rst = 1;
    tick();
    rst = 0;
    #1;
    checks++; if (fill !== 9'd0 || start !== 1'b0) begin errors++; $display("FAIL mid_rst got=%0d/%b exp=0/0", fill, start); end
    checks++; if (wr_ready !== 1'b1 || data !== 16'h0) begin errors++; $display("FAIL mid_rst_state got=%b/%h exp=1/0000", wr_ready, data); end
    do_read(8'd0);
    checks++; if (data !== 16'h0) begin errors++; $display("FAIL load_rd_ignored got=%h exp=0000", data); end
    load_burst(16'h3300, 16'd1, 256, early);
    checks++; if (early !== 0 || start !== 1'b1) begin errors++; $display("FAIL mid_start got=%0d/%b exp=0/1", early, start); end
    tick();
    do_read(8'd0);
    checks++; if (data !== 16'h3300) begin errors++; $display("FAIL mid_rd0 got=%h exp=3300", data); end
    do_read(8'd99);
    checks++; if (data !== 16'h3363) begin errors++; $display("FAIL mid_rd99 got=%h exp=3363", data); end
    do_read(8'd255);
    checks++; if (data !== 16'h33FF) begin errors++; $display("FAIL mid_rd255 got=%h exp=33ff", data); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_serve();
    test_reload();
    test_gaps();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
